// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the multi-channel clock/tick divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_div_pkg;

  // Default counter width; 2^26 covers a 50M count.
  localparam int CNT_W_DEF    = 26;
  // Default reset half-period: 100 Hz from a 50 MHz clock.
  localparam int DEF_HALF_DEF = 250_000;

  // Storage width for programmed counts. A channel's CNT_W must not exceed it;
  // narrower values are zero-extended so compares stay exact.
  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // One programmed setting: high count, low count and a valid flag.
  typedef struct packed {
    cnt_t half;
    cnt_t lo;
    logic vld;
  } ch_cfg_t;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, square-wave output, rise tick, pending/active counts.
// Latency: outputs registered; first rise lo_q edges after enable.
// Backpressure: none; config writes are always accepted into the pending register.
//
// Ports:
//   clk, rst_n   clock, async active-low reset
//   en_i         run enable; low holds the channel cleared
//   sync_clr_i   synchronous restart (phase align with other channels)
//   we_i         write strobe for this channel
//   half_i/lo_i  new high/low counts (equal when duty control is not built)
//   clk_out_o    divided square wave
//   tick_o       one-cycle pulse on the cycle clk_out_o rises
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_HALF = DEF_HALF_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] half_i,
  input  logic [CNT_W-1:0] lo_i,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             out_d, out_q;
  logic             tick_d, tick_q;
  cnt_t             hi_d, hi_q;
  cnt_t             lo_d, lo_q;
  ch_cfg_t          pend_d, pend_q;
  ch_cfg_t          nxt;
  cnt_t             lim;
  logic             idle;
  logic             at_lim;
  logic             apply;

  always_comb begin
    // A write in this cycle supersedes whatever is already pending.
    nxt = pend_q;
    if (we_i) begin
      nxt = '{half: cnt_t'(half_i), lo: cnt_t'(lo_i), vld: 1'b1};
    end

    idle   = (hi_q == '0) || (lo_q == '0);
    lim    = out_q ? hi_q : lo_q;
    at_lim = (cnt_t'(cnt_q) == (lim - cnt_t'(1)));

    apply  = 1'b0;
    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;

    if (sync_clr_i || !en_i || idle) begin
      // Cleared or parked: nothing is running, so a pending value can land now.
      cnt_d = '0;
      out_d = 1'b0;
      apply = 1'b1;
    end else if (at_lim) begin
      cnt_d  = '0;
      out_d  = ~out_q;
      tick_d = ~out_q;
      // Only the high->low toggle closes a full period.
      apply  = out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pend_d = nxt;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (apply && nxt.vld) begin
      hi_d       = nxt.half;
      lo_d       = nxt.lo;
      pend_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
      hi_q   <= cnt_t'(DEF_HALF);
      lo_q   <= cnt_t'(DEF_HALF);
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
    end
  end

  assign clk_out_o = out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/tick generator; NCH independent divider channels.
// Latency: outputs registered; divisor changes take effect at the next period end.
// Backpressure: none; writes to channel indices >= NCH are dropped.
//
// Ports:
//   clk, rst_n    clock, async active-low reset
//   en_i          per-channel run enable
//   sync_clr_i    restart all channels together
//   cfg_we_i      divisor write strobe, cfg_ch_i selects the channel
//   cfg_half_i    new half period (high time when CLK_DIV_DUTY_EN is defined)
//   cfg_lo_i      new low time, present only with CLK_DIV_DUTY_EN
//   clk_out_o     per-channel square wave
//   tick_o        per-channel one-cycle pulse on each clk_out_o rise
// cfg_ch_i carries one extra code point so out-of-range selects are expressible.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int NCH      = 4,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int DEF_HALF = DEF_HALF_DEF,
  localparam int CH_W     = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en_i,
  input  logic             sync_clr_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_half_i,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_W-1:0] cfg_lo_i,
`endif
  output logic [NCH-1:0]   clk_out_o,
  output logic [NCH-1:0]   tick_o
);

  logic [CNT_W-1:0] lo_wr;

`ifdef CLK_DIV_DUTY_EN
  assign lo_wr = cfg_lo_i;
`else
  // 50% duty: the low phase uses the same count as the high phase.
  assign lo_wr = cfg_half_i;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg_we_i && (cfg_ch_i == CH_W'(g));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (en_i[g]),
      .sync_clr_i (sync_clr_i),
      .we_i       (we_ch),
      .half_i     (cfg_half_i),
      .lo_i       (lo_wr),
      .clk_out_o  (clk_out_o[g]),
      .tick_o     (tick_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;
  localparam int NCH      = 2;
  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   en;
  logic             sync_clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_lo;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;
  int exp_q [NCH][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_div_multi #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .sync_clr_i (sync_clr),
    .cfg_we_i   (cfg_we),
    .cfg_ch_i   (cfg_ch),
    .cfg_half_i (cfg_half),
`ifdef CLK_DIV_DUTY_EN
    .cfg_lo_i   (cfg_lo),
`endif
    .clk_out_o  (clk_out),
    .tick_o     (tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input int t);
    exp_q[c].push_back(t);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [CNT_W-1:0] hi, input logic [CNT_W-1:0] lo);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_half = hi;
    cfg_lo   = lo;
  endtask

  // Monitor: every tick must match the next expected rise cycle for its channel.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0] < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL tick_ch%0d missing: wanted at cycle %0d, none by cycle %0d", c, exp_q[c][0], cyc);
        void'(exp_q[c].pop_front());
      end
      if (tick[c] === 1'b1) begin
        if (exp_q[c].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL tick_ch%0d unexpected at cycle %0d, want no tick", c, cyc);
        end else begin
          check($sformatf("tick_ch%0d_cycle", c), cyc, exp_q[c].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = '0; sync_clr = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0; cfg_lo = '0;

    // Default half=3 from enable at edge 2: rises at 5, 11, 17, 23 ...
    push(0, 5); push(0, 11);
    push(1, 5); push(1, 11); push(1, 17); push(1, 23);

    go_to(2);
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_tick", 32'(tick), 0);
    rst_n = 1'b1;
    en    = 2'b11;

    // ch0 just rose at 11; half=1 lands at the fall on 14, then rises every 2nd edge.
    go_to(11);
    cfg_write(2'd0, 8'd1, 8'd1);
    for (int t = 15; t <= 35; t += 2) push(0, t);
    go_to(12);
    cfg_we = 1'b0;

    // ch1 half=0: last period ends with the fall at 26, then idle.
    go_to(21);
    cfg_write(2'd1, 8'd0, 8'd0);
    go_to(22);
    cfg_we = 1'b0;
    go_to(29);
    check("idle_ch1_low", 32'(clk_out[1]), 0);

    // ch1 idle, half=2 applies at edge 31: rises 33, 37, 41, 45, 49.
    go_to(30);
    cfg_write(2'd1, 8'd2, 8'd2);
    push(1, 33); push(1, 37); push(1, 41); push(1, 45); push(1, 49);
    go_to(31);
    cfg_we = 1'b0;

    // ch0 back to half=3 at the fall on 36: rises 39, 45, 51.
    go_to(34);
    cfg_write(2'd0, 8'd3, 8'd3);
    push(0, 39); push(0, 45); push(0, 51);
    go_to(35);
    cfg_we = 1'b0;

    // After edge 52 ch0 is mid-high, ch1 mid-low. Clear with ch1 half=3 written
    // in the same cycle: both low at 53, both rise at 56.
    go_to(52);
    sync_clr = 1'b1;
    cfg_write(2'd1, 8'd3, 8'd3);
    push(0, 56); push(1, 56);
    go_to(53);
    sync_clr = 1'b0;
    cfg_we   = 1'b0;
    check("sync_clr_outputs_low", 32'(clk_out), 0);

    // Async reset while both outputs are high.
    go_to(57);
    check("high_before_reset", 32'(clk_out), 32'h3);
    #2 rst_n = 1'b0;
    #1 check("async_reset_immediate", 32'(clk_out), 0);
`ifdef CLK_DIV_DUTY_EN
    push(0, 62); push(0, 68); push(0, 72); push(0, 76); push(0, 80);
`else
    push(0, 62); push(0, 68); push(0, 74); push(0, 80);
`endif
    push(1, 62); push(1, 68); push(1, 74); push(1, 80);

    // Release at 59 with a write to a nonexistent channel, which must be dropped.
    go_to(59);
    rst_n = 1'b1;
    cfg_write(2'd3, 8'd1, 8'd1);
    go_to(60);
    cfg_we = 1'b0;

`ifdef CLK_DIV_DUTY_EN
    // ch0 1 high / 3 low after the fall at 65: rises 68, 72, 76, 80.
    go_to(63);
    cfg_write(2'd0, 8'd1, 8'd3);
    go_to(64);
    cfg_we = 1'b0;
`endif

    // Disable while outputs are high after the rise at 80.
    go_to(81);
    en = 2'b00;
    go_to(82);
    check("disable_outputs_low", 32'(clk_out), 0);

    go_to(90);
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("ticks_left_ch%0d", c), 32'(exp_q[c].size()), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
